// File: rtl/n_bitdivider_if.sv
// n_bitdivider_if: request/result bundle for the n_bitdivider block.
//   master: drives start, dividend, divisor; observes busy, done and results
//   slave : the divider itself
//   start       request pulse, sampled only while the divider is idle
//   dividend    signed dividend, sampled with start
//   divisor     signed divisor, sampled with start
//   busy        operation in progress
//   done        one-cycle completion pulse
//   quotient    signed quotient, held until the next done
//   remainder   signed remainder, held until the next done
//   div_by_zero divisor was zero for the last completed operation
//   overflow    last completed operation was (-2^(N-1)) / -1
interface n_bitdivider_if #(
    parameter int NUM_BITS = 8
);
    logic                start;
    logic [NUM_BITS-1:0] dividend;
    logic [NUM_BITS-1:0] divisor;
    logic                busy;
    logic                done;
    logic [NUM_BITS-1:0] quotient;
    logic [NUM_BITS-1:0] remainder;
    logic                div_by_zero;
    logic                overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/n_bitdivider.sv
// n_bitdivider: multi-cycle signed restoring divider, one quotient bit per clock.
//   clk    system clock, rising edge
//   n_rst  synchronous active-low reset
//   bus    n_bitdivider_if.slave (start/operands in, busy/done/results/flags out)
// Truncates toward zero; the remainder takes the sign of the dividend.
// Optional macro DIVIDER_ZERO_FAST_EN: a zero divisor skips the CALC phase and
// goes straight to FIXUP; results and flags are the same either way.
module n_bitdivider #(
    parameter int NUM_BITS = 8
) (
    input  logic          clk,
    input  logic          n_rst,
    n_bitdivider_if.slave bus
);
    localparam int N  = NUM_BITS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;

    state_e         state_q, state_d;
    // Partial remainder is kept N bits wide: it is always below |b| <= 2^(N-1),
    // and the N+1-bit trial difference carries the sign of the subtraction.
    logic [N-1:0]   rem_q, rem_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [N-1:0]   bmag_q, bmag_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_quo_q, neg_quo_d;
    logic           neg_rem_q, neg_rem_d;
    logic           divz_q, divz_d;
    logic           ovf_q, ovf_d;

    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [N-1:0]   remd_q, remd_d;
    logic           dbz_q, dbz_d;
    logic           ovfo_q, ovfo_d;

    logic           a_neg, b_neg;
    logic [N-1:0]   a_mag, b_mag;
    logic [N:0]     shifted, diff;

    always_comb begin
        a_neg   = bus.dividend[N-1];
        b_neg   = bus.divisor[N-1];
        a_mag   = a_neg ? -bus.dividend : bus.dividend;
        b_mag   = b_neg ? -bus.divisor  : bus.divisor;
        shifted = {rem_q, quo_q[N-1]};
        diff    = shifted - {1'b0, bmag_q};

        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        bmag_d    = bmag_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        ovf_d     = ovf_q;
        quot_d    = quot_q;
        remd_d    = remd_q;
        dbz_d     = dbz_q;
        ovfo_d    = ovfo_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    quo_d     = a_mag;
                    bmag_d    = b_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    divz_d    = (bus.divisor == '0);
                    ovf_d     = (bus.dividend == {1'b1, {(N-1){1'b0}}}) &&
                                (bus.divisor == '1);
                    state_d   = CALC;
`ifdef DIVIDER_ZERO_FAST_EN
                    // Preload the remainder a full CALC pass would leave: |a|.
                    if (bus.divisor == '0) begin
                        rem_d   = a_mag;
                        state_d = FIXUP;
                    end
`endif
                end
            end
            CALC: begin
                // Restoring step: keep the trial difference only if it is non-negative.
                quo_d = {quo_q[N-2:0], ~diff[N]};
                rem_d = diff[N] ? shifted[N-1:0] : diff[N-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                quot_d  = divz_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
                remd_d  = neg_rem_q ? -rem_q : rem_q;
                dbz_d   = divz_q;
                ovfo_d  = ovf_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CALC) || (state_d == FIXUP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            bmag_q    <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            remd_q    <= '0;
            dbz_q     <= 1'b0;
            ovfo_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            bmag_q    <= bmag_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
            remd_q    <= remd_d;
            dbz_q     <= dbz_d;
            ovfo_q    <= ovfo_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remd_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovfo_q;
endmodule

// File: tb/tb_n_bitdivider.sv
// tb_n_bitdivider: directed and randomized checks of n_bitdivider (NUM_BITS=8)
// against a plain-arithmetic reference of truncating signed division.
module tb_n_bitdivider;
    localparam int NB = 8;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   vectors    = 0;
    int   miscompares = 0;

    n_bitdivider_if #(.NUM_BITS(NB)) bus ();

    n_bitdivider #(.NUM_BITS(NB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer division truncates toward zero, % follows the dividend.
    task automatic ref_div(input logic [NB-1:0] a, input logic [NB-1:0] b,
                           output logic [NB-1:0] q, output logic [NB-1:0] r,
                           output logic dz, output logic ov);
        int ia, ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (ib == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (ia == -128 && ib == -1) begin
            q  = 8'h80;
            r  = '0;
            ov = 1'b1;
        end else begin
            q = NB'(ia / ib);
            r = NB'(ia % ib);
        end
    endtask

    // Called at a negedge with the divider idle; returns at a negedge where a
    // new start may be driven. disturb=1 pokes start/operands mid-operation.
    task automatic run_op(input logic [NB-1:0] a, input logic [NB-1:0] b, input bit disturb);
        logic [NB-1:0] eq, er;
        logic          edz, eov;
        int            edges;
        ref_div(a, b, eq, er, edz, eov);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start = 1'b0;
        edges = 0;
        while (!bus.done && edges < 20) begin
            chk("busy_window", 32'(bus.busy), 32'd1);
            if (disturb && edges == 3) begin
                bus.start    = 1'b1;
                bus.dividend = NB'($urandom);
                bus.divisor  = NB'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        bus.start = 1'b0;
        chk("latency", 32'(edges), 32'd9);
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        chk("quotient", 32'(bus.quotient), 32'(eq));
        chk("remainder", 32'(bus.remainder), 32'(er));
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(edz));
        chk("overflow", 32'(bus.overflow), 32'(eov));
        @(negedge clk);
        chk("done_single", 32'(bus.done), 32'd0);
        chk("quotient_held", 32'(bus.quotient), 32'(eq));
    endtask

    function automatic logic [NB-1:0] pick_operand();
        logic [NB-1:0] corners [6];
        corners = '{8'h80, 8'h81, 8'hFF, 8'h00, 8'h01, 8'h7F};
        if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
        return NB'($urandom);
    endfunction

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        n_rst        = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_quotient", 32'(bus.quotient), 32'd0);
        chk("rst_remainder", 32'(bus.remainder), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        n_rst = 1'b1;

        run_op(8'd100, 8'd7, 1'b0);
        run_op(-8'sd100, 8'd7, 1'b0);
        run_op(8'd100, -8'sd7, 1'b0);
        run_op(-8'sd100, -8'sd7, 1'b0);
        run_op(8'h80, 8'hFF, 1'b0);
        run_op(8'd5, 8'd0, 1'b0);
        run_op(8'h80, 8'd0, 1'b0);
        run_op(8'd100, 8'd7, 1'b1);

        // Reset mid-operation: sampled at edge E0+4.
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_quotient", 32'(bus.quotient), 32'd0);
        chk("midrst_remainder", 32'(bus.remainder), 32'd0);
        chk("midrst_flags", 32'({bus.div_by_zero, bus.overflow}), 32'd0);
        n_rst = 1'b1;
        run_op(-8'sd77, 8'd9, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            run_op(pick_operand(), pick_operand(), ($urandom_range(9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
